sine_sample_gen: RTL and testbench
==================================

Name: sine_sample_gen

Overview:
- Direct-digital-synthesis sample source that sits immediately upstream of the DAC serializer.
- Produces 12-bit offset-binary sine samples at a fixed sample rate derived from Clk.
- Uses a phase accumulator and a quarter-wave LUT.
- Hands each sample to the serializer's parallel DATAIN through a valid/ready handshake, and flags samples the serializer failed to take in time.

Parameters:
- DATA_BITS, 12: output sample width; LUT magnitude width is DATA_BITS-1.
- PHASE_BITS, 16: phase accumulator width.
- LUT_ADDR_BITS, 6: quarter-wave LUT address width (64 entries).
- SAMPLE_DIV, 2000: Clk cycles per sample (100 MHz gives 50 kS/s); legal range is SAMPLE_DIV >= 4.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- En  in  1  sample generation enable.
- Phase_inc  in  PHASE_BITS  phase step per sample; frequency = Phase_inc * Fs / 2^PHASE_BITS.
- Ready  in  1  serializer can accept a sample.
- Valid  out  1  DATAOUT holds a sample not yet transferred.
- DATAOUT  out  DATA_BITS  offset-binary sample; connects to serializer DATAIN.
- Overrun  out  1  sticky: a sample was overwritten before transfer.

Behaviour:
- Reset (Rst=1 at a rising edge): all of the following are cleared.
  - Tick counter = 0, phase_acc = 0, pipeline valid bits = 0.
  - Valid = 0, DATAOUT = 12'h800 (mid-scale), Overrun = 0.
  - Rst applied mid-operation discards all in-flight samples.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while En=1, wrapping to 0.
  - tick = 1 in the cycle where count == SAMPLE_DIV-1.
  - En=0 holds the counter at 0 and suppresses ticks.
  - After En rises, the first tick occurs SAMPLE_DIV cycles later.
- Phase accumulation:
  - On a tick edge, stage 1 captures the current phase_acc.
  - At the same edge, phase_acc <= phase_acc + Phase_inc, modulo 2^PHASE_BITS, wrapping silently.
  - Phase_inc is sampled only at tick edges.
  - The first sample after reset or enable uses phase 0.
- Quadrant decode from the captured phase:
  - q = phase[PHASE_BITS-1 -: 2].
  - a = phase[PHASE_BITS-3 -: LUT_ADDR_BITS].
  - Lower phase bits are truncated; no dithering.
- LUT contents: lut[i] = round(2047 * sin(pi/2 * (i+0.5)/64)), unsigned 11-bit, held in a ROM/case.
  - Anchor values: lut[0] = 25, lut[63] = 2047.
- Stage 2 (registered): mag = lut[a] when q is 0 or 2, lut[~a] when q is 1 or 3.
- Stage 3 (registered into the output):
  - q = 0 or 1: DATAOUT = 2048 + mag.
  - q = 2 or 3: DATAOUT = 2047 - mag.
  - The output never exceeds 4095 and never underflows 0.
- Latency: a tick edge at cycle T gives DATAOUT/Valid updated at edge T+3. This is fixed regardless of Ready.
- Handshake:
  - A transfer occurs at a rising edge with Valid & Ready.
  - Valid falls after a transfer unless a new sample loads at the same edge.
  - DATAOUT is stable while Valid=1 until a transfer or an overwrite.
- Simultaneous events at the output-load edge:
  - Valid=0: load the sample, set Valid=1.
  - Valid=1 and Ready=1: the old sample transfers, the new sample loads, Valid stays 1, no overrun.
  - Valid=1 and Ready=0: the new sample overwrites, Valid stays 1, Overrun <= 1. Overrun is sticky until Rst.
- En falling: in-flight pipeline samples still complete and present normally; no new ticks are generated.
- Ready is ignored while Valid=0.

Test Plan:
- Rst=1 for 3 cycles, then En=0, Ready=0 for 5000 cycles -> Valid=0, DATAOUT=12'h800 and Overrun=0 throughout.
- Phase_inc=0, En=1, Ready=1 -> first Valid exactly SAMPLE_DIV+3 cycles after En rises; every sample is 2073 and is transferred in one cycle; Overrun=0.
- Phase_inc=16'h4000, Ready=1 -> sample sequence 2073, 4095, 2022, 0, 2073, ...; the phase wraps cleanly at the 5th sample.
- Phase_inc=16'h0400 for 64 samples -> one full period; samples 0..15 are monotonically non-decreasing from 2073; samples 32..47 mirror samples 0..15 about 2047.5 (sum = 4095).
- Ready held 0 for 2.5 sample periods -> first sample holds until overwritten; Overrun rises at the second load edge and stays 1; DATAOUT shows the newest sample; Ready=1 then transfers it.
- Rst asserted 1 cycle after a tick edge with Valid=1 -> next cycle Valid=0, DATAOUT=12'h800; no sample emerges from the flushed pipeline.

Source files
------------

// File: rtl/sine_sample_gen.sv
// DDS sine sample source: phase accumulator, quarter-wave LUT and a 3-stage pipeline
// feeding the DAC serializer through a valid/ready hand-off with a sticky overrun flag.
module sine_sample_gen #(
    parameter int DATA_BITS     = 12,
    parameter int PHASE_BITS    = 16,
    parameter int LUT_ADDR_BITS = 6,
    parameter int SAMPLE_DIV    = 2000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic [PHASE_BITS-1:0] Phase_inc,
    input  logic                  Ready,
    output logic                  Valid,
    output logic [DATA_BITS-1:0]  DATAOUT,
    output logic                  Overrun
);
    localparam int MAG_BITS  = DATA_BITS - 1;
    localparam int CNT_BITS  = $clog2(SAMPLE_DIV);
    localparam int PHASE_TOP = 2 + LUT_ADDR_BITS;
    localparam logic [CNT_BITS-1:0]  CNT_LAST  = CNT_BITS'(SAMPLE_DIV - 1);
    localparam logic [DATA_BITS-1:0] MID_SCALE = {1'b1, {MAG_BITS{1'b0}}};

    // round(2047 * sin(pi/2 * (i + 0.5) / 64)); the half-step offset keeps the table symmetric.
    localparam int unsigned LUT_ROM [64] = '{
          25,   75,  126,  176,  226,  275,  325,  375,
         424,  473,  522,  570,  618,  666,  713,  760,
         807,  852,  898,  943,  987, 1031, 1074, 1116,
        1158, 1199, 1239, 1279, 1318, 1356, 1393, 1430,
        1465, 1500, 1533, 1566, 1598, 1629, 1659, 1688,
        1716, 1743, 1769, 1793, 1817, 1840, 1861, 1881,
        1901, 1919, 1936, 1951, 1966, 1979, 1992, 2003,
        2012, 2021, 2028, 2035, 2039, 2043, 2046, 2047
    };

    logic [CNT_BITS-1:0]      cnt_q, cnt_d;
    logic [PHASE_BITS-1:0]    phase_acc_q, phase_acc_d;
    logic                     s1_v_q, s1_v_d;
    logic [PHASE_TOP-1:0]     s1_phase_q, s1_phase_d;
    logic                     s2_v_q, s2_v_d;
    logic [1:0]               s2_quad_q, s2_quad_d;
    logic [MAG_BITS-1:0]      s2_mag_q, s2_mag_d;
    logic                     s3_v_q, s3_v_d;
    logic [DATA_BITS-1:0]     s3_sample_q, s3_sample_d;
    logic                     valid_q, valid_d;
    logic [DATA_BITS-1:0]     dataout_q, dataout_d;
    logic                     overrun_q, overrun_d;

    logic                     tick;
    logic [1:0]               quad;
    logic [LUT_ADDR_BITS-1:0] addr;
    logic [LUT_ADDR_BITS-1:0] lut_idx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick        = En && (cnt_q == CNT_LAST);
        cnt_d       = '0;
        phase_acc_d = '0;
        if (En) begin
            cnt_d       = tick ? '0 : cnt_q + 1'b1;
            phase_acc_d = tick ? phase_acc_q + Phase_inc : phase_acc_q;
        end

        s1_v_d     = tick;
        s1_phase_d = tick ? phase_acc_q[PHASE_BITS-1 -: PHASE_TOP] : s1_phase_q;

        quad      = s1_phase_q[PHASE_TOP-1 -: 2];
        addr      = s1_phase_q[LUT_ADDR_BITS-1:0];
        lut_idx   = quad[0] ? ~addr : addr;
        s2_v_d    = s1_v_q;
        s2_quad_d = quad;
        s2_mag_d  = MAG_BITS'(LUT_ROM[lut_idx]);

        // Lower half is 2047 - mag, i.e. the one's complement of mag with a 0 MSB.
        s3_v_d      = s2_v_q;
        s3_sample_d = s2_quad_q[1] ? {1'b0, ~s2_mag_q} : {1'b1, s2_mag_q};

        valid_d   = valid_q;
        dataout_d = dataout_q;
        overrun_d = overrun_q;
        if (s3_v_q) begin
            valid_d   = 1'b1;
            dataout_d = s3_sample_q;
            overrun_d = overrun_q | (valid_q & ~Ready);
        end else if (valid_q && Ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q       <= '0;
            phase_acc_q <= '0;
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            valid_q     <= 1'b0;
            dataout_q   <= MID_SCALE;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phase_acc_q <= phase_acc_d;
            s1_v_q      <= s1_v_d;
            s2_v_q      <= s2_v_d;
            s3_v_q      <= s3_v_d;
            valid_q     <= valid_d;
            dataout_q   <= dataout_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: pipeline data registers carry no reset; their valid bits decide whether they matter.
    always_ff @(posedge Clk) begin
        s1_phase_q  <= s1_phase_d;
        s2_quad_q   <= s2_quad_d;
        s2_mag_q    <= s2_mag_d;
        s3_sample_q <= s3_sample_d;
    end

    assign Valid   = valid_q;
    assign DATAOUT = dataout_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_sine_sample_gen.sv
// Self-checking bench for sine_sample_gen: directed scenarios plus random phase steps,
// scored against a real-arithmetic sine model and cycle-position timing rules.
module tb_sine_sample_gen;
    localparam int  DIV = 20;
    localparam real PI  = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        Rst;
    logic        En;
    logic [15:0] Phase_inc;
    logic        Ready;
    logic        Valid;
    logic [11:0] DATAOUT;
    logic        Overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int samples[$];

    sine_sample_gen #(
        .DATA_BITS    (12),
        .PHASE_BITS   (16),
        .LUT_ADDR_BITS(6),
        .SAMPLE_DIV   (DIV)
    ) dut (
        .Clk      (clk),
        .Rst      (Rst),
        .En       (En),
        .Phase_inc(Phase_inc),
        .Ready    (Ready),
        .Valid    (Valid),
        .DATAOUT  (DATAOUT),
        .Overrun  (Overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sine of the quantised phase, computed directly from the quadrant rules.
    function automatic logic [11:0] model_sample(input logic [15:0] ph);
        int quad, addr, idx, mag;
        quad = int'(ph[15:14]);
        addr = int'(ph[13:8]);
        idx  = (quad % 2 == 1) ? 63 - addr : addr;
        mag  = $rtoi(2047.0 * $sin(PI / 2.0 * (real'(idx) + 0.5) / 64.0) + 0.5);
        return (quad >= 2) ? 12'(2047 - mag) : 12'(2048 + mag);
    endfunction

    task automatic reset_dut();
        Rst = 1'b1;
        En = 1'b0;
        Ready = 1'b0;
        Phase_inc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", Valid, 0);
        check("reset_data", DATAOUT, 12'h800);
        check("reset_overrun", Overrun, 0);
        Rst = 1'b0;
    endtask

    // Enable for n sample periods with Ready=1; sample k must appear for exactly one
    // cycle, (k+1)*DIV+3 cycles after enable, carrying the sine of the accumulated phase.
    task automatic run_stream(input int n, input logic [15:0] inc0, input bit rnd);
        logic [15:0] acc;
        logic [15:0] ph_q[$];
        logic [15:0] ph;
        acc = '0;
        samples.delete();
        Ready = 1'b1;
        Phase_inc = inc0;
        En = 1'b1;
        for (int c = 1; c <= n * DIV + 6; c++) begin
            @(negedge clk);
            if (c % DIV == 0 && c <= n * DIV) begin
                ph_q.push_back(acc);
                acc = acc + Phase_inc;
            end
            if (c == n * DIV) En = 1'b0;
            if (c >= DIV + 3 && (c - 3) % DIV == 0 && c <= n * DIV + 3) begin
                ph = ph_q.pop_front();
                check("stream_valid", Valid, 1);
                check("stream_data", DATAOUT, model_sample(ph));
                samples.push_back(int'(DATAOUT));
                if (rnd) Phase_inc = 16'($urandom);
            end else begin
                check("stream_idle_valid", Valid, 0);
            end
            check("stream_overrun", Overrun, 0);
        end
    endtask

    initial begin
        int exp_quad[5];
        bit hold;
        exp_quad = '{2073, 4095, 2022, 0, 2073};

        Rst = 1'b1;
        En = 1'b0;
        Ready = 1'b0;
        Phase_inc = '0;
        @(negedge clk);
        reset_dut();

        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            check("idle", {Valid, DATAOUT, Overrun}, {1'b0, 12'h800, 1'b0});
        end

        run_stream(6, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) check("dc_value", samples[i], 2073);

        run_stream(8, 16'h4000, 1'b0);
        for (int i = 0; i < 5; i++) check("quarter_seq", samples[i], exp_quad[i]);

        run_stream(64, 16'h0400, 1'b0);
        check("period_start", samples[0], 2073);
        for (int i = 0; i < 15; i++) check("rising_mono", samples[i + 1] >= samples[i], 1);
        for (int i = 0; i < 16; i++) check("half_mirror", samples[i] + samples[32 + i], 4095);

        run_stream(40, 16'($urandom), 1'b1);

        // Ready low for 2.5 periods: sample 0 held, overwritten by sample 1, then taken.
        Ready = 1'b0;
        Phase_inc = 16'h4000;
        En = 1'b1;
        for (int c = 1; c <= 3 * DIV + 10; c++) begin
            @(negedge clk);
            hold = (c >= DIV + 3) && (c <= (5 * DIV) / 2);
            check("ovr_valid", Valid, hold);
            if (hold) check("ovr_data", DATAOUT, model_sample((c < 2 * DIV + 3) ? 16'h0000 : 16'h4000));
            check("ovr_flag", Overrun, c >= 2 * DIV + 3);
            if (c == (5 * DIV) / 2) begin
                Ready = 1'b1;
                En = 1'b0;
            end
        end

        // Reset one cycle after a tick while a sample waits: everything in flight is dropped.
        reset_dut();
        Ready = 1'b0;
        Phase_inc = 16'h4000;
        En = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check("flush_pre_valid", Valid, 1);
        Rst = 1'b1;
        En = 1'b0;
        @(negedge clk);
        check("flush_valid", Valid, 0);
        check("flush_data", DATAOUT, 12'h800);
        check("flush_overrun", Overrun, 0);
        Rst = 1'b0;
        Ready = 1'b1;
        for (int c = 0; c < 2 * DIV + 5; c++) begin
            @(negedge clk);
            check("flush_quiet", {Valid, DATAOUT}, {1'b0, 12'h800});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
